// File: rtl/rggen_rtl_pkg.sv
// Shared rggen response codes and APB bridge state encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_APB_IDLE     = 2'b00,
        RGGEN_APB_SETUP    = 2'b01,
        RGGEN_APB_ACCESS   = 2'b10,
        RGGEN_APB_RESPONSE = 2'b11
    } rggen_apb_bridge_state;

endpackage

// File: rtl/rggen_bus_apb_bridge_if.sv
// rggen bus request/response plus APB4 signals for one external register window.
interface rggen_bus_apb_bridge_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
);
    localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;

    logic                     bus_valid;
    logic                     bus_ready;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic                     bus_write;
    logic [BUS_WIDTH-1:0]     bus_write_data;
    logic [STRB_WIDTH-1:0]    bus_strobe;
    logic [1:0]               bus_status;
    logic [BUS_WIDTH-1:0]     bus_read_data;

    logic                     psel;
    logic                     penable;
    logic [ADDRESS_WIDTH-1:0] paddr;
    logic [2:0]               pprot;
    logic                     pwrite;
    logic [BUS_WIDTH-1:0]     pwdata;
    logic [STRB_WIDTH-1:0]    pstrb;
    logic                     pready;
    logic [BUS_WIDTH-1:0]     prdata;
    logic                     pslverr;

    // master: the bridge (rggen bus responder, APB master)
    modport master (
        input  bus_valid, bus_address, bus_write, bus_write_data, bus_strobe,
        output bus_ready, bus_status, bus_read_data,
        output psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    // slave: the environment (rggen requester and APB slave)
    modport slave (
        output bus_valid, bus_address, bus_write, bus_write_data, bus_strobe,
        input  bus_ready, bus_status, bus_read_data,
        input  psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/rggen_bus_timer.sv
// Saturating ACCESS-phase wait counter; o_expired flags the last allowed wait cycle.
module rggen_bus_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_disabled
        logic unused_inputs;
        assign unused_inputs = ^{i_clk, i_rst_n, i_clear, i_count};
        assign o_expired     = 1'b0;
    end else begin : g_enabled
        localparam int unsigned COUNT_WIDTH =
            ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
        localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

        logic [COUNT_WIDTH-1:0] count;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                count <= '0;
            end else if (i_clear) begin
                count <= '0;
            end else if (i_count && (count != '1)) begin
                count <= count + COUNT_WIDTH'(1);
            end
        end

        assign o_expired = (count == LIMIT);
    end

endmodule

// File: rtl/rggen_bus_apb_bridge.sv
// Replays a rggen bus request as an APB4 transfer and returns status/read data.
module rggen_bus_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    rggen_bus_apb_bridge_if.master bus_if
);

    localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
    localparam int unsigned LSB_WIDTH  = $clog2(STRB_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = ~ADDRESS_WIDTH'((2 ** LSB_WIDTH) - 1);

    rggen_apb_bridge_state    state;
    logic                     psel;
    logic                     penable;
    logic                     pwrite;
    logic                     ready;
    logic [ADDRESS_WIDTH-1:0] paddr;
    logic [BUS_WIDTH-1:0]     pwdata;
    logic [STRB_WIDTH-1:0]    pstrb;
    logic [BUS_WIDTH-1:0]     read_data;
    rggen_status              status;
    logic                     timer_clear;
    logic                     timer_count;
    logic                     timer_expired;

    assign timer_clear = (state == RGGEN_APB_SETUP);
    assign timer_count = (state == RGGEN_APB_ACCESS) && !bus_if.pready;

    rggen_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (timer_clear),
        .i_count   (timer_count),
        .o_expired (timer_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RGGEN_APB_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            ready     <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            read_data <= '0;
            status    <= RGGEN_OKAY;
        end else begin
            ready <= 1'b0;
            case (state)
                RGGEN_APB_IDLE: begin
                    if (bus_if.bus_valid) begin
                        state   <= RGGEN_APB_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        paddr   <= bus_if.bus_address & ADDRESS_MASK;
                        pwrite  <= bus_if.bus_write;
                        pwdata  <= bus_if.bus_write_data;
                        pstrb   <= bus_if.bus_write ? bus_if.bus_strobe : '0;
                    end
                end
                RGGEN_APB_SETUP: begin
                    state   <= RGGEN_APB_ACCESS;
                    penable <= 1'b1;
                end
                RGGEN_APB_ACCESS: begin
                    if (bus_if.pready) begin
                        state     <= RGGEN_APB_RESPONSE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        ready     <= 1'b1;
                        status    <= bus_if.pslverr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
                        read_data <= (!pwrite && !bus_if.pslverr) ? bus_if.prdata : '0;
                    end else if (timer_expired) begin
                        // Abort a hung slave; late pready is ignored from here on
                        state     <= RGGEN_APB_RESPONSE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        ready     <= 1'b1;
                        status    <= RGGEN_SLAVE_ERROR;
                        read_data <= '0;
                    end
                end
                RGGEN_APB_RESPONSE: begin
                    state <= RGGEN_APB_IDLE;
                end
                default: begin
                    state <= RGGEN_APB_IDLE;
                end
            endcase
        end
    end

    assign bus_if.bus_ready     = ready;
    assign bus_if.bus_status    = status;
    assign bus_if.bus_read_data = read_data;
    assign bus_if.psel          = psel;
    assign bus_if.penable       = penable;
    assign bus_if.paddr         = paddr;
    assign bus_if.pprot         = 3'b000;
    assign bus_if.pwrite        = pwrite;
    assign bus_if.pwdata        = pwdata;
    assign bus_if.pstrb         = pstrb;

    // Upstream must hold a request until it is acknowledged
    a_valid_held: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (bus_if.bus_valid && !bus_if.bus_ready) |=> bus_if.bus_valid
    );

endmodule

// File: tb/tb_rggen_bus_apb_bridge.sv
// Scoreboard bench for rggen_bus_apb_bridge with a randomized APB slave model.
module tb_rggen_bus_apb_bridge;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  st;
        int          en;
    } apb_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    resp_t resp_q[$];
    apb_t  apb_q[$];

    int          cur_waits = 0;
    logic        cur_err   = 1'b0;
    logic [31:0] cur_rdata = '0;

    rggen_bus_apb_bridge_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bif ();

    rggen_bus_apb_bridge #(
        .ADDRESS_WIDTH  (8),
        .BUS_WIDTH      (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB slave: pready after cur_waits ACCESS cycles, junk (pready=1) outside ACCESS
    int acc_k = 0;
    always @(negedge clk) begin
        if (bif.psel && bif.penable) begin
            if (acc_k == cur_waits) begin
                bif.pready  = 1'b1;
                bif.prdata  = cur_rdata;
                bif.pslverr = cur_err;
            end else begin
                bif.pready  = 1'b0;
                bif.prdata  = $urandom;
                bif.pslverr = 1'($urandom_range(0, 1));
            end
            acc_k++;
        end else begin
            acc_k       = 0;
            bif.pready  = 1'b1;
            bif.prdata  = $urandom;
            bif.pslverr = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response or an APB transfer
    apb_t cur;
    bit   active  = 0;
    bit   prev_en = 0;
    int   en_cnt  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            active  = 0;
            prev_en = 0;
            resp_q.delete();
            apb_q.delete();
        end else begin
            if (bif.bus_ready) begin
                if (resp_q.size() == 0) begin
                    check("spurious_ready", 64'(1), 64'(0));
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("status", 64'(bif.bus_status), 64'(r.status));
                    check("read_data", 64'(bif.bus_read_data), 64'(r.rdata));
                    check("ready_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (bif.psel && !bif.penable && !active) begin
                if (apb_q.size() == 0) begin
                    check("spurious_psel", 64'(1), 64'(0));
                end else begin
                    cur    = apb_q.pop_front();
                    active = 1;
                    en_cnt = 0;
                    check("pprot", 64'(bif.pprot), 64'(0));
                end
            end
            if (active && bif.psel) begin
                check("apb_fields", {19'h0, bif.paddr, bif.pwrite, bif.pwdata, bif.pstrb},
                      {19'h0, cur.addr, cur.wr, cur.wd, cur.st});
            end
            if (bif.penable) en_cnt++;
            if (active && prev_en && !bif.penable) begin
                check("penable_cycles", 64'(en_cnt), 64'(cur.en));
                check("psel_dropped", 64'(bif.psel), 64'(0));
                active = 0;
            end
            prev_en = bif.penable;
        end
    end

    // Reference model: response and APB view derived from wait count, error and timeout
    task automatic start_req(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [3:0] st, input int waits, input logic err,
                             input logic [31:0] rd);
        resp_t r;
        apb_t  a;
        bit    timed;
        int    k;
        timed    = (waits >= TIMEOUT);
        k        = timed ? TIMEOUT - 1 : waits;
        r.status = (timed || err) ? 2'b10 : 2'b00;
        r.rdata  = (!wr && !timed && !err) ? rd : 32'h0;
        r.cyc    = cyc + 3 + k;
        a.addr   = {addr[7:2], 2'b00};
        a.wr     = wr;
        a.wd     = wd;
        a.st     = wr ? st : 4'h0;
        a.en     = k + 1;
        resp_q.push_back(r);
        apb_q.push_back(a);
        cur_waits          = waits;
        cur_err            = err;
        cur_rdata          = rd;
        bif.bus_address    = addr;
        bif.bus_write      = wr;
        bif.bus_write_data = wd;
        bif.bus_strobe     = st;
        bif.bus_valid      = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!bif.bus_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bif.bus_ready) check("ready_wait_expired", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bif.bus_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bif.bus_valid      = 1'b0;
        bif.bus_address    = '0;
        bif.bus_write      = 1'b0;
        bif.bus_write_data = '0;
        bif.bus_strobe     = '0;
        repeat (3) @(negedge clk);
        check("rst_psel", 64'(bif.psel), 64'(0));
        check("rst_penable", 64'(bif.penable), 64'(0));
        check("rst_pwrite", 64'(bif.pwrite), 64'(0));
        check("rst_ready", 64'(bif.bus_ready), 64'(0));
        check("rst_paddr", 64'(bif.paddr), 64'(0));
        check("rst_pwdata", 64'(bif.pwdata), 64'(0));
        check("rst_pstrb", 64'(bif.pstrb), 64'(0));
        check("rst_read_data", 64'(bif.bus_read_data), 64'(0));
        check("rst_status", 64'(bif.bus_status), 64'(0));
        rst_n = 1'b1;
        idle(2);

        // Zero-wait write, 3-wait read, errored read, timeout with late pready
        start_req(8'h14, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
        wait_done();
        idle(1);
        start_req(8'h08, 1'b0, 32'h0BAD0BAD, 4'hF, 3, 1'b0, 32'h12345678);
        wait_done();
        idle(1);
        start_req(8'h23, 1'b0, 32'h0, 4'hF, 1, 1'b1, 32'hAAAA5555);
        wait_done();
        idle(1);
        start_req(8'h30, 1'b0, 32'h0, 4'h0, 10, 1'b0, 32'h55555555);
        wait_done();
        idle(4);

        // Reset during ACCESS
        start_req(8'h44, 1'b1, 32'hCAFEF00D, 4'h3, 10, 1'b0, 32'h0);
        for (int i = 0; i < 10 && !bif.penable; i++) @(negedge clk);
        check("penable_before_reset", 64'(bif.penable), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_psel", 64'(bif.psel), 64'(0));
        check("async_rst_penable", 64'(bif.penable), 64'(0));
        check("async_rst_ready", 64'(bif.bus_ready), 64'(0));
        bif.bus_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        start_req(8'h48, 1'b1, 32'h01234567, 4'h5, 1, 1'b0, 32'h0);
        wait_done();

        // Back to back
        start_req(8'h50, 1'b1, 32'h11112222, 4'hC, 0, 1'b0, 32'h0);
        wait_done();
        start_req(8'h54, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h87654321);
        wait_done();

        // Randomized traffic, including timeouts and back-to-back gaps
        for (int t = 0; t < 40; t++) begin
            idle($urandom_range(0, 2));
            start_req(8'($urandom), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                      $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom);
            wait_done();
        end

        idle(6);
        check("resp_q_drained", 64'(resp_q.size()), 64'(0));
        check("apb_q_drained", 64'(apb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
